// File: rtl/boot_inst_rom.sv
// Boot instruction ROM: filled through a byte-serial load stream, then
// answers CPU fetches combinationally once the image is complete. The CPU
// is held in reset until the final byte of the image has been accepted.
module boot_inst_rom #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              cpu_rst_o,
  output logic [ADDR_W:0]   words_o,
  output logic              err_o
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_V  = (ADDR_W+1)'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_word_ptr;
  logic [ADDR_W:0]   r_words;
  logic [31:0]       r_shift;
  logic              r_err;
  logic              r_cpu_rst;
  logic [31:0]       r_mem [DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_word_done;
  logic              w_full;
  logic              w_wr;
  logic              w_partial;
  logic [31:0]       w_word;
  logic [ADDR_W-1:0] w_idx;
  logic              w_hi_zero;
  logic              w_in_range;
  logic              w_unused_addr;

  // Byte-enable bits of the PC are irrelevant for whole-word fetches.
  assign w_unused_addr = ^rom_addr_i[1:0];

  assign w_ready     = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_accept    = ld_valid_i & w_ready;
  // A word closes on its 4th byte, or early when the stream ends.
  assign w_word_done = w_accept & ((r_byte_cnt == 2'd3) | ld_last_i);
  assign w_full      = (r_word_ptr == DEPTH_V);
  assign w_wr        = w_word_done & ~w_full;
  assign w_partial   = w_accept & ld_last_i & (r_byte_cnt != 2'd3);

  assign ld_ready_o  = w_ready;
  assign cpu_rst_o   = r_cpu_rst;
  assign words_o     = r_words;
  assign err_o       = r_err;

  // Next-state decode: first byte leaves IDLE, the last byte enters RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ld_last_i ? ST_RUN : ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_accept && ld_last_i) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Big-endian placement of the incoming byte; unreceived low bytes stay 0.
  always_comb begin
    w_word = 32'h0000_0000;
    case (r_byte_cnt)
      2'd0:    w_word = {ld_data_i, 24'h00_0000};
      2'd1:    w_word = {r_shift[31:24], ld_data_i, 16'h0000};
      2'd2:    w_word = {r_shift[31:16], ld_data_i, 8'h00};
      2'd3:    w_word = {r_shift[31:8], ld_data_i};
      default: w_word = 32'h0000_0000;
    endcase
  end

  // Load-side control state, counters, sticky error and CPU reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= 2'd0;
      r_word_ptr <= ZERO_V;
      r_words    <= ZERO_V;
      r_shift    <= 32'h0000_0000;
      r_err      <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= w_word_done ? 32'h0000_0000 : w_word;
      end
      if (w_wr) begin
        r_word_ptr <= r_word_ptr + ONE_V;
        r_words    <= r_words + ONE_V;
      end
      if ((w_word_done & w_full) | w_partial) begin
        r_err <= 1'b1;
      end
      if (w_state_nxt == ST_RUN) begin
        r_cpu_rst <= 1'b0;
      end
    end
  end

  // Image storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_word_ptr[ADDR_W-1:0]] <= w_word;
    end
  end

  assign w_idx      = rom_addr_i[ADDR_W+1:2];
  assign w_hi_zero  = (rom_addr_i[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
  assign w_in_range = ({1'b0, w_idx} < r_words);

  // Zero-latency fetch; anything not loaded or out of window reads as 0.
  always_comb begin
    rom_data_o = 32'h0000_0000;
    if ((r_state == ST_RUN) && rom_ce_i && w_hi_zero && w_in_range) begin
      rom_data_o = r_mem[w_idx];
    end else begin
      rom_data_o = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_boot_inst_rom.sv
// Scoreboard bench for boot_inst_rom: stimulus pushes expected values,
// a monitor on the falling edge pops and compares them.
module tb_boot_inst_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default depth
  logic        rst_a, ldv_a, ldl_a, ce_a, rdy_a, cpurst_a, err_a;
  logic [7:0]  ldd_a;
  logic [31:0] addr_a, data_a;
  logic [10:0] words_a;
  // Instance B: 4-word depth for overflow
  logic        rst_b, ldv_b, ldl_b, ce_b, rdy_b, cpurst_b, err_b;
  logic [7:0]  ldd_b;
  logic [31:0] addr_b, data_b;
  logic [2:0]  words_b;

  boot_inst_rom #(.ADDR_W(10)) u_dut_a (
    .clk(clk), .rst(rst_a), .ld_valid_i(ldv_a), .ld_data_i(ldd_a),
    .ld_last_i(ldl_a), .ld_ready_o(rdy_a), .rom_ce_i(ce_a),
    .rom_addr_i(addr_a), .rom_data_o(data_a), .cpu_rst_o(cpurst_a),
    .words_o(words_a), .err_o(err_a)
  );

  boot_inst_rom #(.ADDR_W(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .ld_valid_i(ldv_b), .ld_data_i(ldd_b),
    .ld_last_i(ldl_b), .ld_ready_o(rdy_b), .rom_ce_i(ce_b),
    .rom_addr_i(addr_b), .rom_data_o(data_b), .cpu_rst_o(cpurst_b),
    .words_o(words_b), .err_o(err_b)
  );

  localparam int K_DATA_A = 0, K_WORDS_A = 1, K_ERR_A = 2, K_CPURST_A = 3,
                 K_RDY_A = 4, K_DATA_B = 5, K_WORDS_B = 6, K_ERR_B = 7,
                 K_CPURST_B = 8, K_RDY_B = 9;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       tag;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_DATA_A:   return data_a;
      K_WORDS_A:  return 32'(words_a);
      K_ERR_A:    return 32'(err_a);
      K_CPURST_A: return 32'(cpurst_a);
      K_RDY_A:    return 32'(rdy_a);
      K_DATA_B:   return data_b;
      K_WORDS_B:  return 32'(words_b);
      K_ERR_B:    return 32'(err_b);
      K_CPURST_B: return 32'(cpurst_b);
      K_RDY_B:    return 32'(rdy_b);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compares every pending expectation mid-cycle.
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] got;
    while (q.size() > 0) begin
      c   = q.pop_front();
      got = actual(c.kind);
      n_checks++;
      if (got !== c.exp) begin
        n_errors++;
        $display("FAIL %s: got %08h expected %08h", c.tag, got, c.exp);
      end
    end
  end

  task automatic expect_v(input int kind, input logic [31:0] e, input string tag);
    chk_t c;
    c.kind = kind;
    c.exp  = e;
    c.tag  = tag;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic last);
    ldv_a = 1'b1; ldd_a = d; ldl_a = last;
    tick();
    ldv_a = 1'b0; ldl_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic last);
    ldv_b = 1'b1; ldd_b = d; ldl_b = last;
    tick();
    ldv_b = 1'b0; ldl_b = 1'b0;
  endtask

  task automatic rd_a(input logic [31:0] a, input logic ce, input logic [31:0] e, input string tag);
    ce_a = ce; addr_a = a;
    expect_v(K_DATA_A, e, tag);
    tick();
  endtask

  task automatic rd_b(input logic [31:0] a, input logic [31:0] e, input string tag);
    ce_b = 1'b1; addr_b = a;
    expect_v(K_DATA_B, e, tag);
    tick();
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();
  endtask

  logic [7:0] img1 [8];
  logic [7:0] img2 [5];
  logic [7:0] img4 [4];

  initial begin
    img1 = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    img4 = '{8'h12, 8'h34, 8'h56, 8'h78};
    rst_a = 1'b0; ldv_a = 1'b0; ldd_a = 8'h00; ldl_a = 1'b0; ce_a = 1'b0; addr_a = 32'h0;
    rst_b = 1'b0; ldv_b = 1'b0; ldd_b = 8'h00; ldl_b = 1'b0; ce_b = 1'b0; addr_b = 32'h0;
    tick();
    expect_v(K_WORDS_A, 32'd0, "rst_words_a");
    expect_v(K_ERR_A, 32'd0, "rst_err_a");
    expect_v(K_CPURST_A, 32'd1, "rst_cpurst_a");
    expect_v(K_RDY_A, 32'd1, "rst_ready_a");
    expect_v(K_WORDS_B, 32'd0, "rst_words_b");
    expect_v(K_CPURST_B, 32'd1, "rst_cpurst_b");
    tick();
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    // Two-word image
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        ce_a = 1'b1; addr_a = 32'h0;
        expect_v(K_DATA_A, 32'h0, "load_fetch_blocked");
        expect_v(K_WORDS_A, 32'd1, "load_words_mid");
      end
      if (i == 7) begin
        expect_v(K_CPURST_A, 32'd1, "cpurst_before_last");
        expect_v(K_RDY_A, 32'd1, "ready_in_load");
      end
      send_a(img1[i], (i == 7));
      ce_a = 1'b0;
    end
    expect_v(K_WORDS_A, 32'd2, "img1_words");
    expect_v(K_ERR_A, 32'd0, "img1_err");
    expect_v(K_CPURST_A, 32'd0, "img1_cpurst");
    expect_v(K_RDY_A, 32'd0, "ready_in_run");
    rd_a(32'h0, 1'b1, 32'h3401_1100, "img1_addr0");
    rd_a(32'h4, 1'b1, 32'h3402_0020, "img1_addr4");
    rd_a(32'h8, 1'b1, 32'h0000_0000, "img1_addr8");
    rd_a(32'h0, 1'b0, 32'h0000_0000, "img1_ce_off");
    rd_a(32'h0, 1'b1, 32'h3401_1100, "img1_ce_on");
    // Bytes offered in RUN must be ignored
    send_a(8'hFF, 1'b0);
    send_a(8'hEE, 1'b1);
    expect_v(K_WORDS_A, 32'd2, "run_ignore_words");
    rd_a(32'h4, 1'b1, 32'h3402_0020, "run_ignore_data");
    rd_a(32'h8, 1'b1, 32'h0000_0000, "run_ignore_addr8");

    // Partial final word
    ce_a = 1'b0;
    reset_a();
    for (int i = 0; i < 5; i++) send_a(img2[i], (i == 4));
    expect_v(K_WORDS_A, 32'd2, "img2_words");
    expect_v(K_ERR_A, 32'd1, "img2_err");
    expect_v(K_CPURST_A, 32'd0, "img2_cpurst");
    rd_a(32'h3, 1'b1, 32'hAABB_CCDD, "img2_misaligned");
    rd_a(32'h4, 1'b1, 32'hEE00_0000, "img2_padded");
    rd_a(32'h8, 1'b1, 32'h0000_0000, "img2_addr8");
    rd_a(32'h8000_0000, 1'b1, 32'h0000_0000, "img2_high_addr");

    // Reset in the middle of a load, then throttled reload
    ce_a = 1'b0;
    reset_a();
    for (int i = 0; i < 6; i++) send_a(8'h50 + 8'(i), 1'b0);
    expect_v(K_WORDS_A, 32'd1, "midload_words");
    tick();
    rst_a = 1'b0;
    expect_v(K_CPURST_A, 32'd1, "midrst_cpurst");
    expect_v(K_WORDS_A, 32'd0, "midrst_words");
    expect_v(K_ERR_A, 32'd0, "midrst_err");
    tick();
    rst_a = 1'b1;
    rd_a(32'h0, 1'b1, 32'h0000_0000, "idle_fetch");
    ce_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_a(img4[i], (i == 3));
      if (i < 3) begin
        expect_v(K_RDY_A, 32'd1, "throttle_ready");
        tick();
      end
    end
    expect_v(K_WORDS_A, 32'd1, "reload_words");
    expect_v(K_ERR_A, 32'd0, "reload_err");
    rd_a(32'h0, 1'b1, 32'h1234_5678, "reload_addr0");
    rd_a(32'h4, 1'b1, 32'h0000_0000, "stale_hidden");

    // Overflow on the 4-word instance
    for (int i = 0; i < 20; i++) begin
      if (i == 16) begin
        expect_v(K_WORDS_B, 32'd4, "ovf_words_full");
        expect_v(K_ERR_B, 32'd0, "ovf_err_before");
      end
      send_b(8'(i), (i == 19));
    end
    expect_v(K_WORDS_B, 32'd4, "ovf_words_sat");
    expect_v(K_ERR_B, 32'd1, "ovf_err");
    expect_v(K_CPURST_B, 32'd0, "ovf_cpurst");
    expect_v(K_RDY_B, 32'd0, "ovf_ready_run");
    rd_b(32'h0,  32'h0001_0203, "ovf_addr0");
    rd_b(32'h8,  32'h0809_0A0B, "ovf_addr8");
    rd_b(32'hC,  32'h0C0D_0E0F, "ovf_addrC");
    rd_b(32'h10, 32'h0000_0000, "ovf_out_of_range");

    for (int k = 0; k < 10 && q.size() > 0; k++) tick();
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/boot_inst_rom.md
Name: boot_inst_rom

Overview:
- Instruction-memory responder for the CPU fetch interface: the CPU drives `rom_ce`/`rom_addr` and this block returns `rom_data`.
- Before execution it is filled through a byte-serial load stream (valid/ready), e.g. from a UART or testbench loader.
- It holds the CPU in reset until the final byte is accepted, then serves fetches combinationally so the CPU's registered-PC / IF-ID timing is met without stalls.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- ld_valid_i  in  1  load byte valid.
- ld_data_i  in  8  load byte.
- ld_last_i  in  1  qualifies the final byte of the image; sampled only with ld_valid_i.
- ld_ready_o  out  1  block can accept a load byte.
- rom_ce_i  in  1  CPU fetch enable.
- rom_addr_i  in  32  CPU byte address (PC).
- rom_data_o  out  32  instruction word.
- cpu_rst_o  out  1  CPU reset, active-high; held 1 until the image is loaded.
- words_o  out  ADDR_W+1  number of words written.
- err_o  out  1  sticky error flag: overflow or partial final word.

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset values (async, rst=0): state=IDLE, byte_cnt=0, word_ptr=0, shift reg=0, words_o=0, err_o=0, cpu_rst_o=1. Memory array is not cleared.
- Byte handshake: a byte is accepted on a rising edge with ld_valid_i & ld_ready_o.
- ld_ready_o = 1 in IDLE and LOAD, 0 in RUN (combinational from state).
- IDLE->LOAD: on the first accepted byte without ld_last_i.
- IDLE->RUN or LOAD->RUN: on an accepted byte with ld_last_i.
- RUN is terminal until rst. Bytes presented in RUN are ignored.
- Assembly is big-endian: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0]. byte_cnt wraps 3->0.
- Full-word write:
  - On the edge accepting the 4th byte, {shift[31:8], ld_data_i} is written to mem[word_ptr] in the same edge; no extra cycle.
  - word_ptr and words_o then increment.
- Partial final word (ld_last_i with byte_cnt != 3):
  - The word is written with the unreceived low bytes zero-padded.
  - words_o increments and err_o is set.
- Overflow: when word_ptr == 2**ADDR_W, further full words are dropped, err_o is set, and words_o saturates at 2**ADDR_W. Bytes are still accepted so the stream drains.
- cpu_rst_o is registered: it goes 0 on the same edge that enters RUN, so the final word is readable in the first cycle the CPU is out of reset.
- Read path (combinational): rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when all of the following hold; otherwise 0:
  - state == RUN;
  - rom_ce_i = 1;
  - rom_addr_i[31:ADDR_W+2] == 0;
  - word index < words_o.
- rom_addr_i[1:0] is ignored.
- Reset mid-load: all state returns to reset values immediately (async). The partial assembly is discarded, cpu_rst_o returns to 1, and stale memory contents are unreadable because words_o=0.
- Simultaneous ld_valid_i and rom_ce_i in LOAD: the load proceeds and rom_data_o=0.

Test Plan:
- Load 0x34,0x01,0x11,0x00,0x34,0x02,0x00,0x20 with ld_last_i on the 8th byte -> words_o=2, cpu_rst_o falls on that edge, err_o=0; in RUN, addr 0x0 -> 0x34011100, addr 0x4 -> 0x34020020, addr 0x8 -> 0x00000000.
- Load 0xAA,0xBB,0xCC,0xDD,0xEE (last on 5th) -> words_o=2, word1=0xEE000000, err_o=1; addr 0x3 (misaligned) -> 0xAABBCCDD.
- ADDR_W=2: stream 20 bytes 0x00..0x13, last on 20th -> words_o=4, err_o=1; addr 0xC -> 0x0C0D0E0F; addr 0x10 (out of range) -> 0.
- Pulse rst=0 after 6 bytes -> cpu_rst_o=1 and words_o=0 immediately; reload 4 bytes 0x12,0x34,0x56,0x78 with last -> addr 0 -> 0x12345678.
- Throttle ld_valid_i every other cycle, and present ld_valid_i in RUN -> byte order preserved, ld_ready_o=0 in RUN, no writes after RUN.
- In RUN with rom_ce_i=0 -> rom_data_o=0; with rom_ce_i=1 -> data visible the same cycle (zero latency).
